// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mul_pkg
//  Description : Shared state encoding and default sizing for the sequential
//                shift-and-add multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
package mul_pkg;

    localparam int MUL_WIDTH = 32;
    localparam int MUL_CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } mul_state_e;

endpackage : mul_pkg
`default_nettype wire

// File: rtl/mul_seq_dp.sv
`default_nettype none
// ============================================================================
//  Module      : mul_seq_dp
//  Description : Multiplier datapath: operand/accumulator registers, one
//                WIDTH-bit adder with carry-out, shifter and product negator.
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_seq_dp
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_i,
    input  logic               step_i,
    input  logic               neg_en_i,
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   src1_i,
    input  logic [WIDTH-1:0]   src2_i,
    output logic [2*WIDTH-1:0] res_o
);

    localparam int PW = 2 * WIDTH;

    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             neg_q, neg_d;

    logic [WIDTH-1:0] abs1, abs2;
    logic [WIDTH:0]   sum;
    logic [PW-1:0]    prod_raw, prod_fix;

    always_comb begin
        // The most negative operand maps onto itself, read back as unsigned.
        abs1 = (signed_i && src1_i[WIDTH-1]) ? (~src1_i + WIDTH'(1)) : src1_i;
        abs2 = (signed_i && src2_i[WIDTH-1]) ? (~src2_i + WIDTH'(1)) : src2_i;

        sum      = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
        prod_raw = {hi_q, lo_q};
        prod_fix = neg_q ? (~prod_raw + PW'(1)) : prod_raw;

        mcand_d = mcand_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        neg_d   = neg_q;

        if (load_i) begin
            mcand_d = abs1;
            lo_d    = abs2;
            hi_d    = '0;
            neg_d   = signed_i & (src1_i[WIDTH-1] ^ src2_i[WIDTH-1]);
        end else if (step_i) begin
            // Carry-out shifts into hi[MSB]; low sum bit drops into lo[MSB].
            hi_d = sum[WIDTH:1];
            lo_d = {sum[0], lo_q[WIDTH-1:1]};
        end else if (neg_en_i) begin
            {hi_d, lo_d} = prod_fix;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mcand_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            neg_q   <= 1'b0;
        end else begin
            mcand_q <= mcand_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            neg_q   <= neg_d;
        end
    end

    assign res_o = prod_fix;

endmodule : mul_seq_dp
`default_nettype wire

// File: rtl/mul_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mul_seq_ctrl
//  Description : Fixed-latency signed/unsigned sequential multiplier with a
//                start/busy/done handshake and synchronous flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_seq_ctrl
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH,
    parameter int CNT_W = MUL_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] prod_hi_o,
    output logic [WIDTH-1:0] prod_lo_o
);

    mul_state_e           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;

    logic                 accept, last_iter;
    logic                 load, step, neg_en;
    logic [2*WIDTH-1:0]   dp_res;

    always_comb begin
        accept    = start_i && !flush_i && (state_q == IDLE || state_q == DONE);
        last_iter = (cnt_q == CNT_W'(WIDTH - 1));
        load      = accept;
        step      = (state_q == CALC) && !flush_i;
        neg_en    = (state_q == SIGN) && !flush_i;

        state_d = state_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = accept ? CALC : IDLE;
                if (accept) cnt_d = '0;
            end
            CALC: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last_iter) state_d = SIGN;
                end
            end
            SIGN: begin
                // Result is captured with the sign fix so it is valid during DONE.
                if (flush_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                    prod_d  = dp_res;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == CALC) || (state_d == SIGN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            prod_q  <= prod_d;
        end
    end

    mul_seq_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load_i   (load),
        .step_i   (step),
        .neg_en_i (neg_en),
        .signed_i (signed_i),
        .src1_i   (src1_i),
        .src2_i   (src2_i),
        .res_o    (dp_res)
    );

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign prod_hi_o = prod_q[2*WIDTH-1:WIDTH];
    assign prod_lo_o = prod_q[WIDTH-1:0];

endmodule : mul_seq_ctrl
`default_nettype wire

// File: tb/tb_mul_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul_seq_ctrl
//  Description : Directed self-checking bench for mul_seq_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        sgn = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] src1 = '0;
    logic [31:0] src2 = '0;
    logic        busy, done;
    logic [31:0] prod_hi, prod_lo;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mul_seq_ctrl dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .start_i   (start),
        .signed_i  (sgn),
        .flush_i   (flush),
        .src1_i    (src1),
        .src2_i    (src2),
        .busy_o    (busy),
        .done_o    (done),
        .prod_hi_o (prod_hi),
        .prod_lo_o (prod_lo)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; starts an op and returns at the negedge where done is seen.
    task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input int inj, input logic [63:0] exp);
        int k = 0;
        int nbusy = 0;
        int ngap = 0;
        bit seen = 0;
        start = 1'b1; src1 = a; src2 = b; sgn = s;
        while (!seen && k < 60) begin
            @(negedge clk);
            k++;
            if (k == 1) start = 1'b0;
            if (k == inj) begin start = 1'b1; src1 = 32'd2; src2 = 32'd2; end
            if (k == inj + 1) start = 1'b0;
            if (done) begin
                seen = 1;
                chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
            end else if (busy) nbusy++;
            else ngap++;
        end
        chk({tag, "_latency"}, 64'(k), 64'd34);
        chk({tag, "_busy_cycles"}, 64'(nbusy), 64'd33);
        chk({tag, "_idle_gap"}, 64'(ngap), 64'd0);
        chk({tag, "_prod"}, {prod_hi, prod_lo}, exp);
    endtask

    initial begin
        int k;
        bit any_done;

        repeat (2) @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_prod", {prod_hi, prod_lo}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run("u_small", 32'd3, 32'd5, 1'b0, 0, 64'h0000_0000_0000_000F);
        @(negedge clk);
        chk("u_small_done_pulse", 64'(done), 64'd0);
        chk("u_small_idle", 64'(busy), 64'd0);

        run("u_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 64'hFFFF_FFFE_0000_0001);
        @(negedge clk);
        run("s_m3x5", 32'hFFFF_FFFD, 32'd5, 1'b1, 0, 64'hFFFF_FFFF_FFFF_FFF1);
        @(negedge clk);
        run("s_minxmin", 32'h8000_0000, 32'h8000_0000, 1'b1, 0, 64'h4000_0000_0000_0000);
        @(negedge clk);
        run("s_minx1", 32'h8000_0000, 32'd1, 1'b1, 0, 64'hFFFF_FFFF_8000_0000);
        @(negedge clk);

        // Start ignored while busy, then back-to-back start in the DONE cycle.
        run("busy_ign", 32'd7, 32'd6, 1'b0, 10, 64'd42);
        run("b2b", 32'd9, 32'd9, 1'b0, 0, 64'd81);
        @(negedge clk);
        chk("b2b_done_pulse", 64'(done), 64'd0);
        chk("b2b_idle", 64'(busy), 64'd0);

        // Flush mid-calculation leaves the previous result in place.
        start = 1'b1; src1 = 32'd100; src2 = 32'd100; sgn = 1'b0;
        k = 0;
        while (k < 12) begin
            @(negedge clk);
            k++;
            if (k == 1) start = 1'b0;
            if (k == 5) chk("flush_hold_prev", {prod_hi, prod_lo}, 64'd81);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", 64'(busy), 64'd0);
        chk("flush_done", 64'(done), 64'd0);
        any_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) any_done = 1;
        end
        chk("flush_no_done", 64'(any_done), 64'd0);
        chk("flush_prod", {prod_hi, prod_lo}, 64'd81);

        // Asynchronous reset between edges while in CALC.
        start = 1'b1; src1 = 32'd4; src2 = 32'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("areset_busy", 64'(busy), 64'd0);
        chk("areset_done", 64'(done), 64'd0);
        chk("areset_prod", {prod_hi, prod_lo}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run("post_reset", 32'd4, 32'd4, 1'b0, 0, 64'd16);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_mul_seq_ctrl
`default_nettype wire

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
- Multi-cycle sequencer that drives a single WIDTH-bit adder to compute a full 2*WIDTH-bit product by iterative shift-and-add.
- Sits beside the ALU in the execute stage and serves MULT/MULTU.
- Uses a start/busy/done handshake so the pipeline controller can stall while it runs.
- Supports signed (two's complement) and unsigned operands with fixed latency.

Parameters:
- WIDTH, 32, operand width in bits. Product is 2*WIDTH bits.
- CNT_W, 6, width of the iteration counter. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- start_i  input  1  request a multiply. Sampled only when the block is accepting.
- signed_i  input  1  1 = signed operands, 0 = unsigned. Sampled with start_i.
- flush_i  input  1  synchronous abort of any operation in flight.
- src1_i  input  WIDTH  multiplicand. Sampled with start_i.
- src2_i  input  WIDTH  multiplier. Sampled with start_i.
- busy_o  output  1  high while in CALC or SIGN.
- done_o  output  1  single-cycle pulse when the result becomes valid.
- prod_hi_o  output  WIDTH  upper half of the product.
- prod_lo_o  output  WIDTH  lower half of the product.

Behaviour:
- Reset (async, any time, including mid-operation):
  - state=IDLE, counter=0.
  - busy_o=0, done_o=0, prod_hi_o=0, prod_lo_o=0.
  - Internal operand and sign registers are cleared.
- States: IDLE, CALC, SIGN, DONE.
- Accept condition: start_i=1 while state is IDLE or DONE, and flush_i=0. On accept:
  - Latch mcand = |src1| and lo = |src2| when signed_i=1; raw values otherwise.
  - Latch neg = signed_i & (src1[MSB] ^ src2[MSB]).
  - Set hi=0, counter=0, and go to CALC.
  - Absolute value of the most negative operand (0x80000000) is 0x80000000, treated as unsigned. No overflow.
- CALC, one iteration per cycle:
  - If lo[0]=1, then {c,hi} = hi + mcand, else {c,hi} = {0,hi}.
  - Then shift {c,hi,lo} right by one bit.
  - counter increments each iteration. After exactly WIDTH iterations, go to SIGN.
- SIGN, one cycle, always taken so latency is fixed:
  - If neg=1, replace {hi,lo} with its two's complement across 2*WIDTH bits. Otherwise hold.
  - Go to DONE.
- DONE, one cycle:
  - done_o=1.
  - prod_hi_o/prod_lo_o are updated to {hi,lo} on the same edge that enters DONE, so they are valid while done_o=1.
  - Then go to IDLE, unless a new start is accepted, in which case go to CALC (back-to-back).
- Latency: a start accepted on edge N gives done_o=1 during the cycle after edge N+WIDTH+1. For WIDTH=32 that is 34 cycles of busy/done from acceptance.
- Result holding: prod_*_o hold their value until the next DONE or reset. flush_i and a new start do not disturb them.
- start_i while busy_o=1: ignored, not queued. Operands are not re-sampled.
- flush_i=1:
  - From CALC or SIGN, go to IDLE next edge. No done_o pulse. Outputs are unchanged.
  - In IDLE or DONE, flush_i has priority over start_i; the start is dropped.
- Width rules:
  - The adder is WIDTH bits plus carry-out. The carry is captured into the shift, never dropped.
  - Unsigned results are exact for all 2^(2*WIDTH) operand pairs.
- done_o and busy_o are never high in the same cycle.

Decomposition:
- Shared package mul_pkg holds:
  - State encoding constants: IDLE=2'd0, CALC=2'd1, SIGN=2'd2, DONE=2'd3.
  - MUL_WIDTH=32 and MUL_CNT_W=6 defaults.
- One natural sub-module, mul_seq_dp: the datapath holding mcand/hi/lo registers, the WIDTH-bit adder with carry-out, the shifter and the 2*WIDTH-bit negator. It is driven by load/step/neg_en strobes.
- mul_seq_ctrl keeps the FSM, counter and handshake outputs.

Test Plan:
- Unsigned small: signed_i=0, src1=3, src2=5, start one cycle. Required: busy_o high for 33 cycles, done_o pulses exactly once, prod = 0x00000000_0000000F, then IDLE.
- Unsigned max: 0xFFFFFFFF*0xFFFFFFFF. Required: prod = 0xFFFFFFFE_00000001, which exercises the carry-out on every add.
- Signed mixed and extremes:
  - -3*5 (0xFFFFFFFD, 5) gives 0xFFFFFFFF_FFFFFFF1.
  - 0x80000000*0x80000000 gives 0x40000000_00000000.
  - 0x80000000*1 gives 0xFFFFFFFF_80000000.
- Busy and back-to-back:
  - Start 7*6. Pulse start with 2*2 at cycle 10: it is ignored, and the result is 42 at the expected done cycle.
  - Assert start with 9*9 during the DONE cycle: accepted. Second done_o arrives 34 cycles later with 81, and no IDLE cycle occurs in between.
- Flush: start 100*100, then flush_i at cycle 12. Required: busy_o low next cycle, no done_o, and prod_*_o still hold the previous result.
- Async reset mid-CALC (asserted between clock edges): all outputs go to 0 immediately. After release, a fresh 4*4 completes normally with prod = 16.
